// File: rtl/lut_port_arbiter_pkg.sv
// Shared constants for the OLED curve-LUT port arbiter: LUT geometry and requester IDs.
package lut_port_arbiter_pkg;

  localparam int LUT_NUM_ENTRIES = 19;
  localparam int LUT_DATA_WIDTH  = 8;
  localparam int LUT_ADDR_WIDTH  = 8;

  // Requester 0 is the brightness/fade engine, requester 1 the pixel colour mapper.
  typedef enum logic {
    REQ_FADE = 1'b0,
    REQ_CMAP = 1'b1
  } req_id_e;

endpackage

// File: rtl/lut_port_arbiter_if.sv
// Requester handshakes and LUT RAM port bundled for the curve-LUT arbiter.
interface lut_port_arbiter_if
  import lut_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
);

  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  oob0;

  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  oob1;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  // The master side is the requesters together with the LUT RAM sitting beside the arbiter.
  modport slave (
    input  req0, addr0, req1, addr1, ram_dout,
    output gnt0, rvalid0, rdata0, oob0,
    output gnt1, rvalid1, rdata1, oob1,
    output ram_addr
  );

  modport master (
    output req0, addr0, req1, addr1, ram_dout,
    input  gnt0, rvalid0, rdata0, oob0,
    input  gnt1, rvalid1, rdata1, oob1,
    input  ram_addr
  );

endinterface

// File: rtl/lut_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; the priority flips to the other requester after every grant.
module rr_arbiter2
  import lut_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_id_e prio_q;
  req_id_e prio_d;

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    // Grants are suppressed while reset is asserted so nothing enters the pipeline.
    if (rst_n) begin
      if (req0 && (!req1 || prio_q == REQ_FADE)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      prio_d = REQ_CMAP;
    end else if (gnt1) begin
      prio_d = REQ_FADE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_FADE;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/lut_port_arbiter.sv
// Shares the single-port curve LUT between two requesters; one lookup per cycle,
// data returned two cycles after the grant and steered back to its owner.
module lut_port_arbiter
  import lut_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = LUT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH,
  parameter int NUM_ENTRIES = LUT_NUM_ENTRIES
)(
  input  logic                clk,
  input  logic                rst_n,
  lut_port_arbiter_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = ADDR_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  // Returns {clamped flag, in-range address}.
  function automatic logic [ADDR_WIDTH:0] clamp_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a > MAX_ADDR) begin
      return {1'b1, MAX_ADDR};
    end
    return {1'b0, a};
  endfunction

  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH:0]   clamped;

  logic [ADDR_WIDTH-1:0] ram_addr_p1;
  logic                  vld_p1;
  req_id_e               own_p1;
  logic                  oob_p1;

  logic                  vld_p2;
  req_id_e               own_p2;
  logic                  oob_p2;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign sel_addr = gnt1 ? bus.addr1 : bus.addr0;
  assign clamped  = clamp_addr(sel_addr);

  // Stage 1: latch the granted, clamped address into the RAM address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_p1 <= '0;
      vld_p1      <= 1'b0;
      own_p1      <= REQ_FADE;
      oob_p1      <= 1'b0;
    end else begin
      vld_p1 <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        ram_addr_p1 <= clamped[ADDR_WIDTH-1:0];
        own_p1      <= gnt1 ? REQ_CMAP : REQ_FADE;
        oob_p1      <= clamped[ADDR_WIDTH];
      end
    end
  end

  assign bus.ram_addr = ram_addr_p1;

  // Stage 2: tag travels alongside the RAM's own output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      own_p2 <= REQ_FADE;
      oob_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      own_p2 <= own_p1;
      oob_p2 <= oob_p1;
    end
  end

  // Response: stale RAM output is masked whenever no tagged lookup is present.
  assign bus.rvalid0 = vld_p2 && (own_p2 == REQ_FADE);
  assign bus.rvalid1 = vld_p2 && (own_p2 == REQ_CMAP);
  assign bus.rdata0  = bus.rvalid0 ? bus.ram_dout : ZERO_DATA;
  assign bus.rdata1  = bus.rvalid1 ? bus.ram_dout : ZERO_DATA;
  assign bus.oob0    = oob_p2 & bus.rvalid0;
  assign bus.oob1    = oob_p2 & bus.rvalid1;

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Bench for lut_port_arbiter: vector table for grants, response scoreboard, reset corner cases.
module tb_lut_port_arbiter;

  logic clk;
  logic rst_n;

  lut_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  lut_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] lut [256];

  // Registered-output lookup RAM beside the arbiter; never reset.
  always @(posedge clk) bus.ram_dout <= lut[bus.ram_addr];

  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic       g0;
    logic       g1;
  } vec_t;

  typedef struct {
    int         due;
    logic       own;
    logic [7:0] data;
    logic       oob;
  } resp_t;

  vec_t  vecs [18];
  resp_t sb [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_data(input logic [7:0] a);
    return (a > 8'd18) ? lut[18] : lut[a];
  endfunction

  task automatic check_outputs(input string tag, input logic eg0, input logic eg1);
    resp_t      e;
    logic       ev0 = 1'b0;
    logic       ev1 = 1'b0;
    logic [7:0] ed0 = 8'h00;
    logic [7:0] ed1 = 8'h00;
    logic       eo0 = 1'b0;
    logic       eo1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.own == 1'b0) begin
        ev0 = 1'b1; ed0 = e.data; eo0 = e.oob;
      end else begin
        ev1 = 1'b1; ed1 = e.data; eo1 = e.oob;
      end
    end
    check({tag, " gnt0"},    8'(bus.gnt0),    8'(eg0));
    check({tag, " gnt1"},    8'(bus.gnt1),    8'(eg1));
    check({tag, " rvalid0"}, 8'(bus.rvalid0), 8'(ev0));
    check({tag, " rvalid1"}, 8'(bus.rvalid1), 8'(ev1));
    check({tag, " rdata0"},  bus.rdata0,      ed0);
    check({tag, " rdata1"},  bus.rdata1,      ed1);
    check({tag, " oob0"},    8'(bus.oob0),    8'(eo0));
    check({tag, " oob1"},    8'(bus.oob1),    8'(eo1));
  endtask

  // One clock cycle: drive, check combinational grant and due responses, push expectations.
  task automatic step(input string tag, input logic r0, input logic [7:0] a0,
                      input logic r1, input logic [7:0] a1, input logic eg0, input logic eg1);
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
    #1;
    check_outputs(tag, eg0, eg1);
    if (eg0) sb.push_back('{due: cyc + 2, own: 1'b0, data: ref_data(a0), oob: (a0 > 8'd18)});
    if (eg1) sb.push_back('{due: cyc + 2, own: 1'b1, data: ref_data(a1), oob: (a1 > 8'd18)});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'(i * 5 + 1);
    lut[0]  = 8'h00;
    lut[1]  = 8'h06;
    lut[2]  = 8'h07;
    lut[5]  = 8'h0B;
    lut[9]  = 8'h2D;
    lut[18] = 8'h5A;

    vecs[0]  = '{1'b1, 8'd9,   1'b0, 8'd0,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'd0,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd0,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd0,   1'b1, 8'd0,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'd0,   1'b1, 8'd1,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'd0,   1'b1, 8'd2,  1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'd5,   1'b1, 8'd18, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'd5,   1'b1, 8'd18, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'd5,   1'b1, 8'd18, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'd5,   1'b1, 8'd18, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'd18,  1'b0, 8'd0,  1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'd19,  1'b0, 8'd0,  1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'd255, 1'b0, 8'd0,  1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'd3,   1'b1, 8'd7,  1'b0, 1'b1};
    vecs[14] = '{1'b1, 8'd6,   1'b1, 8'd4,  1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'd0,   1'b0, 8'd4,  1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'd0,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'd0,   1'b0, 8'd0,  1'b0, 1'b0};

    // Power-on reset with both requests pending: nothing may be granted.
    rst_n     = 1'b0;
    bus.req0  = 1'b1;
    bus.addr0 = 8'd3;
    bus.req1  = 1'b1;
    bus.addr1 = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    check("reset ram_addr", bus.ram_addr, 8'h00);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1,
           vecs[i].g0, vecs[i].g1);
    end
    check("drained", 8'(sb.size()), 8'd0);

    // Grant to requester 0, then a one-cycle reset pulse while both request.
    step("pre-rst", 1'b1, 8'd9, 1'b0, 8'd0, 1'b1, 1'b0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    rst_n    = 1'b0;
    #1;
    sb.delete();
    check_outputs("in-rst", 1'b0, 1'b0);
    check("in-rst ram_addr", bus.ram_addr, 8'h00);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs("in-rst2", 1'b0, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n    = 1'b1;
    step("post-rst0", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step("post-rst1", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step("post-rst2", 1'b1, 8'd5, 1'b1, 8'd18, 1'b1, 1'b0);
    step("post-rst3", 1'b1, 8'd5, 1'b1, 8'd18, 1'b0, 1'b1);
    step("post-rst4", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step("post-rst5", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step("post-rst6", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("final drained", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
